// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: opcode encoding and shadow-capture rule.
// Optional build macro used by this slice: UNIV_REG_SAT_EN (saturating INC/DEC).
package univ_reg_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD    = 3'b000,
        OP_LOAD    = 3'b001,
        OP_SHL     = 3'b010,
        OP_SHR     = 3'b011,
        OP_INC     = 3'b100,
        OP_DEC     = 3'b101,
        OP_ROTL    = 3'b110,
        OP_RESTORE = 3'b111
    } op_e;

    // Every state-changing op snapshots the old value so one step can be undone.
    function automatic logic shadow_capture(input op_e op);
        return (op != OP_HOLD) && (op != OP_RESTORE);
    endfunction

endpackage

// File: rtl/univ_reg_alu.sv
// Combinational next-value / next-carry logic for univ_reg.
// Defining UNIV_REG_SAT_EN makes INC/DEC saturate instead of wrapping.
module univ_reg_alu
    import univ_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_ser_in,
    input  logic [WIDTH-1:0] i_shadow,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_q_c,
    output logic             o_carry_c
);

    logic w_all_ones;
    logic w_all_zero;

    assign w_all_ones = &i_q;
    assign w_all_zero = ~|i_q;

    always_comb begin
        o_q_c     = i_q;
        o_carry_c = i_carry;
        unique case (i_op)
            OP_HOLD: begin
                o_q_c     = i_q;
                o_carry_c = i_carry;
            end
            OP_LOAD: begin
                o_q_c     = i_load_val;
                o_carry_c = 1'b0;
            end
            OP_SHL: begin
                o_q_c     = {i_q[WIDTH-2:0], i_ser_in};
                o_carry_c = i_q[WIDTH-1];
            end
            OP_SHR: begin
                o_q_c     = {i_ser_in, i_q[WIDTH-1:1]};
                o_carry_c = i_q[0];
            end
            OP_INC: begin
`ifdef UNIV_REG_SAT_EN
                o_q_c     = w_all_ones ? i_q : i_q + WIDTH'(1);
`else
                o_q_c     = i_q + WIDTH'(1);
`endif
                o_carry_c = w_all_ones;
            end
            OP_DEC: begin
`ifdef UNIV_REG_SAT_EN
                o_q_c     = w_all_zero ? i_q : i_q - WIDTH'(1);
`else
                o_q_c     = i_q - WIDTH'(1);
`endif
                o_carry_c = w_all_zero;
            end
            OP_ROTL: begin
                o_q_c     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_carry_c = i_q[WIDTH-1];
            end
            OP_RESTORE: begin
                o_q_c     = i_shadow;
                o_carry_c = 1'b0;
            end
            default: begin
                o_q_c     = i_q;
                o_carry_c = i_carry;
            end
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// Parametrised universal register: load, shift, count, rotate and single-step undo.
// Build option: UNIV_REG_SAT_EN selects saturating INC/DEC inside univ_reg_alu.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic             carry,
    output logic             zero,
    output logic             tc
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("univ_reg: WIDTH must be within 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic [WIDTH-1:0] r_shadow;

    op_e              w_op;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_carry;
    logic             w_capture;

    assign w_op      = op_e'(op);
    assign w_capture = shadow_capture(w_op);

    univ_reg_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_q        (r_q),
        .i_op       (w_op),
        .i_load_val (loadVal),
        .i_ser_in   (ser_in),
        .i_shadow   (r_shadow),
        .i_carry    (r_carry),
        .o_q_c      (w_next_q),
        .o_carry_c  (w_next_carry)
    );

    // clr beats enable, enable beats op; shadow keeps the pre-op value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q      <= RST_VAL;
            r_carry  <= 1'b0;
            r_shadow <= RST_VAL;
        end else if (enable) begin
            r_q     <= w_next_q;
            r_carry <= w_next_carry;
            if (w_capture) begin
                r_shadow <= r_q;
            end
        end
    end

    assign Q     = r_q;
    assign carry = r_carry;
    assign zero  = ~|r_q;
    assign tc    = &r_q;

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg (WIDTH=8): directed plan plus random ops against an arithmetic model.
module tb_univ_reg;

    localparam int unsigned W   = 8;
    localparam int          MOD = 256;

    logic         clk = 1'b0;
    logic         clr;
    logic         enable;
    logic [2:0]   op;
    logic [W-1:0] loadVal;
    logic         ser_in;
    logic [W-1:0] Q;
    logic         carry;
    logic         zero;
    logic         tc;

    always #5 clk = ~clk;

    univ_reg #(
        .WIDTH   (W),
        .RST_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .enable  (enable),
        .op      (op),
        .loadVal (loadVal),
        .ser_in  (ser_in),
        .Q       (Q),
        .carry   (carry),
        .zero    (zero),
        .tc      (tc)
    );

    typedef struct {
        int    q;
        int    c;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: integer value, carry flag and undo copy.
    int m_q  = 0;
    int m_c  = 0;
    int m_sh = 0;

    task automatic chk(input string name, input string tag, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, req);
        end
    endtask

    // Applies one cycle of stimulus and queues what the register must show after the edge.
    task automatic step(input int c, input int e, input int o, input int lv, input int si,
                        input string tag);
        int old;
        exp_t x;
        @(negedge clk);
        clr     = 1'(c);
        enable  = 1'(e);
        op      = 3'(o);
        loadVal = W'(lv);
        ser_in  = 1'(si);
        old = m_q;
        if (c != 0) begin
            m_q = 0; m_c = 0; m_sh = 0;
        end else if (e != 0) begin
            if (o != 0 && o != 7) m_sh = old;
            case (o)
                1: begin m_q = lv % MOD; m_c = 0; end
                2: begin m_q = (old * 2 + si) % MOD; m_c = old / (MOD / 2); end
                3: begin m_q = si * (MOD / 2) + old / 2; m_c = old % 2; end
                4: begin
                    m_c = (old == MOD - 1) ? 1 : 0;
`ifdef UNIV_REG_SAT_EN
                    m_q = (old == MOD - 1) ? old : old + 1;
`else
                    m_q = (old + 1) % MOD;
`endif
                end
                5: begin
                    m_c = (old == 0) ? 1 : 0;
`ifdef UNIV_REG_SAT_EN
                    m_q = (old == 0) ? 0 : old - 1;
`else
                    m_q = (old + MOD - 1) % MOD;
`endif
                end
                6: begin m_q = (old * 2) % MOD + old / (MOD / 2); m_c = old / (MOD / 2); end
                7: begin m_q = m_sh; m_c = 0; end
                default: ;
            endcase
        end
        x.q = m_q; x.c = m_c; x.tag = tag;
        sb.push_back(x);
    endtask

    // Monitor: one result per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("Q",     e.tag, int'(Q),     e.q);
                chk("carry", e.tag, int'(carry), e.c);
                chk("zero",  e.tag, int'(zero),  (e.q == 0) ? 1 : 0);
                chk("tc",    e.tag, int'(tc),    (e.q == MOD - 1) ? 1 : 0);
            end
        end
    end

    initial begin
        clr = 1'b0; enable = 1'b0; op = 3'd0; loadVal = '0; ser_in = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 1, 4, 0,    0, "reset");
        step(0, 0, 1, 'h5A, 0, "gated_load");
        step(0, 1, 1, 'h81, 0, "load81");
        step(0, 1, 2, 0,    1, "shl");
        step(0, 1, 3, 0,    0, "shr");
        step(0, 1, 1, 'hFF, 0, "loadFF");
        step(0, 1, 4, 0,    0, "inc_top");
        step(0, 1, 5, 0,    0, "dec");
        step(0, 1, 1, 'h00, 0, "load00");
        step(0, 1, 5, 0,    0, "dec_bottom");
        step(0, 1, 1, 'h3C, 0, "load3C");
        step(0, 1, 4, 0,    0, "inc3C");
        step(0, 1, 7, 0,    0, "restore1");
        step(0, 1, 7, 0,    0, "restore2");
        step(0, 1, 1, 'h80, 0, "load80");
        step(0, 1, 6, 0,    0, "rotl");
        step(0, 1, 0, 'h12, 1, "hold");
        step(0, 1, 1, 'hAA, 0, "loadAA");
        step(1, 1, 4, 0,    0, "clr_over_inc");
        step(0, 1, 7, 0,    0, "restore_after_clr");

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)),
                 "random");
        end

        repeat (3) @(posedge clk);
        #2;
        chk("drain", "scoreboard", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
